busctl: RTL and testbench
=========================

# busctl

Bus-cycle front end for the Playground 68030 CPU board, sitting directly upstream of the DRAM controller. It decodes the CPU address and function codes into active-low chip selects (`nRAMSEL` to the DRAM controller, `nROMSEL`, `nIOSEL`). It maintains the reset-time ROM overlay that maps boot ROM at address 0. It runs a bus watchdog that asserts `BERR` when no `/DSACK` arrives within a bounded number of clocks.

## Interface
- `TIMEOUT`, default 255: clocks in WAIT without DSACK before `BERR`; legal range 2..255.
- `CLK`  in  1  system clock, 50 MHz (DRAM controller clock).
- `RST`  in  1  asynchronous, active-high reset.
- `nAS`  in  1  CPU address strobe, asynchronous to `CLK`.
- `RnW`  in  1  CPU read/write; 1 = read.
- `FC`  in  3  CPU function codes.
- `ADDR`  in  12  CPU `A[31:20]`.
- `nDSACK`  in  2  sensed bus `/DSACK1:0`, active-low, asynchronous.
- `nRAMSEL`  out  1  DRAM select, active-low.
- `nROMSEL`  out  1  ROM select, active-low.
- `nIOSEL`  out  1  I/O space select, active-low.
- `BERR`  out  1  active-high; drives the external open-drain inverter onto `/BERR`.
- `OVERLAY`  out  1  1 while the boot overlay is active.

## Operation
- Decode is combinational and gated by `~nAS`. It is blocked entirely when `FC == 3'b111` (CPU space).
  - RAM region: `ADDR[31:28] == 4'h0`.
  - ROM region: `ADDR[31:24] == 8'hFF` and `ADDR[23:20] != 4'hF`.
  - IO region: `ADDR[31:20] == 12'hFFF`.
  - Any other address: unmapped, no select asserted.
- Overlay behaviour:
  - While `OVERLAY = 1`, reads in the RAM region assert `nROMSEL` instead of `nRAMSEL`.
  - Writes in the RAM region always assert `nRAMSEL`.
  - At most one select is low at any time. All selects are high whenever `nAS = 1`.
- Synchronizers:
  - `nAS` uses two flops (`AS1` → `AS`, active-high internally).
  - `nDSACK` uses two flops to produce `DS = |~nDSACK` (synchronized).
- `OVERLAY` is set to 1 by reset. It is cleared on the IDLE→WAIT edge if the synchronized cycle decodes to the ROM region, using the non-overlay decode with FC ≠ 7. Once cleared, it stays 0 until the next reset.
- Watchdog FSM, 8-bit counter `cnt`:
  - IDLE: `BERR = 0`. If `AS`, go to WAIT with `cnt <= 0`.
  - WAIT:
    - If `~AS`, go to IDLE.
    - Else if `DS`, go to ACKED.
    - Else if `cnt == TIMEOUT-1`, go to FAULT and set `BERR <= 1`.
    - Else `cnt <= cnt+1`.
  - ACKED: if `~AS`, go to IDLE.
  - FAULT: hold `BERR = 1`. If `~AS`, go to IDLE and set `BERR <= 0`.
- The watchdog applies to all cycles: unmapped addresses, CPU space, and selected devices that never acknowledge.
- Simultaneous events:
  - `DS` and the terminal count in the same WAIT cycle: DS wins, ACKED, no `BERR`.
  - `~AS` and `DS` together: `~AS` wins, IDLE.
- Reset:
  - Values: state = IDLE, `cnt = 0`, `BERR = 0`, `OVERLAY = 1`, all synchronizer flops 0.
  - Reset is effective immediately at any point, including mid-WAIT or mid-FAULT.

## Timing
- Selects follow `nAS`, `ADDR`, `FC`, `RnW` and `OVERLAY` combinationally. There is no clock latency.
- `nAS` falling to `AS` high takes 2 `CLK` edges. The WAIT entry edge follows one edge later.
- `BERR` rises exactly `TIMEOUT` clock edges after the WAIT-entry edge when `DS` is never seen.
- `DS` lags `nDSACK` by 2 edges. The DRAM controller's `DSACK` is therefore seen 2 clocks after it asserts.
- `BERR` falls on the first edge at which `AS` samples 0, i.e. 2–3 clocks after `nAS` rises.
- `OVERLAY` falls on the WAIT-entry edge of the first ROM-region cycle. It affects decode from that edge on.
- Reset output values, asynchronous: `BERR = 0`, `OVERLAY = 1`. With `nAS = 1`: `nRAMSEL = nROMSEL = nIOSEL = 1`.

## Test plan
- Reset, then hold `RST = 0` with `nAS = 1`, idle for 10 clocks → `BERR = 0`, `OVERLAY = 1`, all selects 1.
- Overlay read: read at `ADDR = 12'h000`, `FC = 5` → `nROMSEL = 0`, `nRAMSEL = 1`. Write at the same address → `nRAMSEL = 0`, `nROMSEL = 1`.
- Overlay clear: read at `ADDR = 12'hFF0` → `OVERLAY` drops 3 edges after `nAS` falls. A following read at `12'h000` → `nRAMSEL = 0`.
- Timeout: read at `12'h800` (unmapped), `nDSACK = 2'b11` held, `TIMEOUT = 255` → `BERR` rises exactly 255 edges after WAIT entry. `nAS` rises → `BERR = 0` within 3 clocks.
- Race: `nDSACK = 2'b00` timed so `DS` first samples 1 on the terminal-count cycle → no `BERR`, FSM goes to ACKED. `FC = 7` at `12'h000` → no select, `BERR` after `TIMEOUT`.
- Reset mid-FAULT: pulse `RST` while `BERR = 1` → `BERR = 0` and `OVERLAY = 1` immediately. The next unmapped cycle times out normally.

Source files
------------

// File: rtl/busctl_if.sv
// CPU-side bus bundle for the 68030 bus-cycle front end.
// Latency: none, this is a plain signal bundle.
// Backpressure: none; cycle termination comes from the nDSACK pair.
// Ports: master = CPU/bus side (strobe, address, FC, RnW, sensed DSACK),
//        slave  = busctl (chip selects, BERR, OVERLAY).
interface busctl_if;
  logic        nAS;
  logic        RnW;
  logic [2:0]  FC;
  logic [11:0] ADDR;
  logic [1:0]  nDSACK;
  logic        nRAMSEL;
  logic        nROMSEL;
  logic        nIOSEL;
  logic        BERR;
  logic        OVERLAY;

  modport master (
    output nAS, RnW, FC, ADDR, nDSACK,
    input  nRAMSEL, nROMSEL, nIOSEL, BERR, OVERLAY
  );

  modport slave (
    input  nAS, RnW, FC, ADDR, nDSACK,
    output nRAMSEL, nROMSEL, nIOSEL, BERR, OVERLAY
  );
endinterface

// File: rtl/busctl.sv
// Bus-cycle front end: chip-select decode, boot ROM overlay, bus watchdog.
// Latency: selects are combinational; AS/DS are seen 2 clocks late; BERR
//   rises TIMEOUT clocks after WAIT entry. Backpressure: none, DSACK ends a cycle.
// Ports: CLK, RST (async, active-high); bus = busctl_if.slave.
module busctl #(
  parameter int unsigned TIMEOUT = 255  // legal range 2..255
) (
  input  logic     CLK,
  input  logic     RST,
  busctl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACKED = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       berr_q, berr_d;
  logic       overlay_q, overlay_d;
  logic       as1_q, as1_d, as_q, as_d;
  logic       ds1_q, ds1_d, ds_q, ds_d;

  // Region decode on the raw CPU address.
  logic cpu_space, ram_rgn, rom_rgn, io_rgn, cs_en;

  always_comb begin
    cpu_space = (bus.FC == 3'b111);
    ram_rgn   = (bus.ADDR[11:8] == 4'h0);
    rom_rgn   = (bus.ADDR[11:4] == 8'hFF) && (bus.ADDR[3:0] != 4'hF);
    io_rgn    = (bus.ADDR == 12'hFFF);
    cs_en     = ~bus.nAS & ~cpu_space;
  end

  // Overlay steers RAM-region reads to the boot ROM; writes still reach DRAM.
  assign bus.nRAMSEL = ~(cs_en & ram_rgn & (~bus.RnW | ~overlay_q));
  assign bus.nROMSEL = ~(cs_en & (rom_rgn | (ram_rgn & bus.RnW & overlay_q)));
  assign bus.nIOSEL  = ~(cs_en & io_rgn);
  assign bus.BERR    = berr_q;
  assign bus.OVERLAY = overlay_q;

  always_comb begin
    as1_d     = ~bus.nAS;
    as_d      = as1_q;
    ds1_d     = |(~bus.nDSACK);
    ds_d      = ds1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    berr_d    = berr_q;
    overlay_d = overlay_q;

    case (state_q)
      ST_IDLE: begin
        berr_d = 1'b0;
        if (as_q) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd0;
          // First real ROM access ends the boot overlay for good.
          if (rom_rgn && !cpu_space) overlay_d = 1'b0;
        end
      end
      ST_WAIT: begin
        // Priority: strobe release, then acknowledge, then terminal count.
        if (!as_q) begin
          state_d = ST_IDLE;
        end else if (ds_q) begin
          state_d = ST_ACKED;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_FAULT;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ACKED: begin
        if (!as_q) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        berr_d = 1'b1;
        if (!as_q) begin
          state_d = ST_IDLE;
          berr_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      berr_q    <= 1'b0;
      overlay_q <= 1'b1;
      as1_q     <= 1'b0;
      as_q      <= 1'b0;
      ds1_q     <= 1'b0;
      ds_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      berr_q    <= berr_d;
      overlay_q <= overlay_d;
      as1_q     <= as1_d;
      as_q      <= as_d;
      ds1_q     <= ds1_d;
      ds_q      <= ds_d;
    end
  end

endmodule

// File: tb/tb_busctl.sv
// Self-checking bench for busctl: directed scenarios plus randomized bus cycles
// checked against a behavioural model of decode, overlay and watchdog timing.
// Edge numbers below count CLK rising edges after nAS is driven low.
module tb_busctl;
  localparam int T = 255;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   ovl_m;

  busctl_if bif ();

  busctl #(.TIMEOUT(T)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL sim_time_limit: got no finish, want finish");
    $fatal(1);
  end

  // Expected {nRAMSEL,nROMSEL,nIOSEL} from the address map.
  function automatic logic [2:0] exp_sel(logic [11:0] a, logic [2:0] fc,
                                         logic rnw, logic nas, bit ovl);
    int v;
    v = int'(a);
    if (nas || fc == 3'd7) return 3'b111;
    if (v < 'h100) return (ovl && rnw) ? 3'b101 : 3'b011;
    if (v >= 'hFF0 && v <= 'hFFE) return 3'b101;
    if (v == 'hFFF) return 3'b110;
    return 3'b111;
  endfunction

  function automatic bit is_rom(logic [11:0] a, logic [2:0] fc);
    return (fc != 3'd7) && (int'(a) >= 'hFF0) && (int'(a) <= 'hFFE);
  endfunction

  // Edge at which BERR should rise (0 = never). nDSACK driven before edge k
  // becomes visible to the watchdog at edge max(k+2,4); WAIT starts at edge 3
  // and the last edge at which DS can still rescue the cycle is 3+T.
  function automatic int exp_berr_edge(int k);
    if (k != 0 && k <= T + 1) return 0;
    return 3 + T;
  endfunction

  function automatic logic [2:0] sel_now();
    return {bif.nRAMSEL, bif.nROMSEL, bif.nIOSEL};
  endfunction

  // Start a bus cycle and run nedges clocks. k = edge before which nDSACK is
  // driven with ds_pat (0 = never). Returns observations only.
  task automatic run_cycle(input logic [11:0] a, input logic [2:0] fc,
                           input logic rnw, input logic [1:0] ds_pat,
                           input int k, input int nedges,
                           output logic [2:0] sel0, output logic ovl2,
                           output logic ovl3, output int berr_first,
                           output bit berr_drop);
    @(negedge clk);
    bif.ADDR = a;
    bif.FC   = fc;
    bif.RnW  = rnw;
    bif.nAS  = 1'b0;
    #1 sel0 = sel_now();
    berr_first = 0;
    berr_drop  = 1'b0;
    ovl2 = 1'bx;
    ovl3 = 1'bx;
    for (int e = 1; e <= nedges; e++) begin
      if (e == k) bif.nDSACK = ds_pat;
      @(posedge clk);
      @(negedge clk);
      if (e == 2) ovl2 = bif.OVERLAY;
      if (e == 3) ovl3 = bif.OVERLAY;
      if (bif.BERR === 1'b1 && berr_first == 0) berr_first = e;
      if (bif.BERR !== 1'b1 && berr_first != 0) berr_drop = 1'b1;
    end
  endtask

  // Release the strobe; BERR sampled after the 2nd and 3rd following edges.
  task automatic end_cycle(output logic b2, output logic b3);
    bif.nAS    = 1'b1;
    bif.nDSACK = 2'b11;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    b2 = bif.BERR;
    @(posedge clk); @(negedge clk);
    b3 = bif.BERR;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bif.nAS    = 1'b1;
    bif.nDSACK = 2'b11;
    bif.ADDR   = 12'h000;
    bif.FC     = 3'd5;
    bif.RnW    = 1'b1;
    ovl_m      = 1'b1;
    #2;
    total++; if (bif.BERR !== 1'b0) begin bad++; $display("FAIL reset_berr: got %b want 0", bif.BERR); end
    total++; if (bif.OVERLAY !== 1'b1) begin bad++; $display("FAIL reset_overlay: got %b want 1", bif.OVERLAY); end
    total++; if (sel_now() !== 3'b111) begin bad++; $display("FAIL reset_sel: got %b want 111", sel_now()); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (bif.BERR !== 1'b0) begin bad++; $display("FAIL idle_berr: got %b want 0", bif.BERR); end
    total++; if (bif.OVERLAY !== 1'b1) begin bad++; $display("FAIL idle_overlay: got %b want 1", bif.OVERLAY); end
    total++; if (sel_now() !== 3'b111) begin bad++; $display("FAIL idle_sel: got %b want 111", sel_now()); end
  endtask

  task automatic test_overlay_rdwr();
    logic [2:0] exp;
    @(negedge clk);
    bif.ADDR = 12'h000;
    bif.FC   = 3'd5;
    bif.RnW  = 1'b1;
    bif.nAS  = 1'b0;
    #1;
    exp = exp_sel(12'h000, 3'd5, 1'b1, 1'b0, ovl_m);
    total++; if (sel_now() !== exp) begin bad++; $display("FAIL ovl_read_sel: got %b want %b", sel_now(), exp); end
    bif.RnW = 1'b0;
    #1;
    exp = exp_sel(12'h000, 3'd5, 1'b0, 1'b0, ovl_m);
    total++; if (sel_now() !== exp) begin bad++; $display("FAIL ovl_write_sel: got %b want %b", sel_now(), exp); end
    bif.nAS = 1'b1;   // released before the strobe can be synchronized
    bif.RnW = 1'b1;
    #1;
    total++; if (sel_now() !== 3'b111) begin bad++; $display("FAIL nas_high_sel: got %b want 111", sel_now()); end
  endtask

  task automatic test_overlay_clear();
    logic [2:0] s0, exp;
    logic o2, o3, b2, b3;
    int bf;
    bit bd;
    exp = exp_sel(12'hFF0, 3'd5, 1'b1, 1'b0, ovl_m);
    run_cycle(12'hFF0, 3'd5, 1'b1, 2'b10, 1, 6, s0, o2, o3, bf, bd);
    total++; if (s0 !== exp) begin bad++; $display("FAIL rom_sel: got %b want %b", s0, exp); end
    total++; if (o2 !== 1'b1) begin bad++; $display("FAIL ovl_edge2: got %b want 1", o2); end
    ovl_m = 1'b0;
    total++; if (o3 !== 1'b0) begin bad++; $display("FAIL ovl_edge3: got %b want 0", o3); end
    total++; if (bf != 0) begin bad++; $display("FAIL rom_acked_berr: got edge %0d want 0", bf); end
    end_cycle(b2, b3);
    exp = exp_sel(12'h000, 3'd5, 1'b1, 1'b0, ovl_m);
    run_cycle(12'h000, 3'd5, 1'b1, 2'b01, 2, 6, s0, o2, o3, bf, bd);
    total++; if (s0 !== exp) begin bad++; $display("FAIL post_ovl_read_sel: got %b want %b", s0, exp); end
    total++; if (o3 !== 1'b0) begin bad++; $display("FAIL ovl_sticky: got %b want 0", o3); end
    end_cycle(b2, b3);
  endtask

  task automatic test_timeout();
    logic [2:0] s0;
    logic o2, o3, b2, b3;
    int bf;
    bit bd;
    run_cycle(12'h800, 3'd5, 1'b1, 2'b11, 0, 3 + T + 2, s0, o2, o3, bf, bd);
    total++; if (s0 !== 3'b111) begin bad++; $display("FAIL unmapped_sel: got %b want 111", s0); end
    total++; if (bf != exp_berr_edge(0)) begin bad++; $display("FAIL timeout_edge: got %0d want %0d", bf, exp_berr_edge(0)); end
    total++; if (bd) begin bad++; $display("FAIL timeout_hold: got drop 1 want 0"); end
    end_cycle(b2, b3);
    total++; if (b2 !== 1'b1) begin bad++; $display("FAIL berr_hold_edge2: got %b want 1", b2); end
    total++; if (b3 !== 1'b0) begin bad++; $display("FAIL berr_clear_edge3: got %b want 0", b3); end
  endtask

  task automatic test_race();
    logic [2:0] s0;
    logic o2, o3, b2, b3;
    int bf;
    bit bd;
    // DS first seen on the terminal-count edge: acknowledge wins.
    run_cycle(12'h800, 3'd5, 1'b1, 2'b00, T + 1, 3 + T + 3, s0, o2, o3, bf, bd);
    total++; if (bf != exp_berr_edge(T + 1)) begin bad++; $display("FAIL race_ds_wins: got edge %0d want %0d", bf, exp_berr_edge(T + 1)); end
    end_cycle(b2, b3);
    total++; if (b3 !== 1'b0) begin bad++; $display("FAIL race_end_berr: got %b want 0", b3); end
    // One edge later is too late.
    run_cycle(12'h800, 3'd5, 1'b1, 2'b00, T + 2, 3 + T + 3, s0, o2, o3, bf, bd);
    total++; if (bf != exp_berr_edge(T + 2)) begin bad++; $display("FAIL race_late_ds: got edge %0d want %0d", bf, exp_berr_edge(T + 2)); end
    end_cycle(b2, b3);
  endtask

  task automatic test_cpu_space();
    logic [2:0] s0;
    logic o2, o3, b2, b3;
    int bf;
    bit bd;
    run_cycle(12'h000, 3'd7, 1'b1, 2'b11, 0, 3 + T + 2, s0, o2, o3, bf, bd);
    total++; if (s0 !== 3'b111) begin bad++; $display("FAIL cpu_space_sel: got %b want 111", s0); end
    total++; if (bf != exp_berr_edge(0)) begin bad++; $display("FAIL cpu_space_berr: got edge %0d want %0d", bf, exp_berr_edge(0)); end
    end_cycle(b2, b3);
  endtask

  task automatic test_reset_mid_fault();
    logic [2:0] s0;
    logic o2, o3, b2, b3;
    int bf;
    bit bd;
    run_cycle(12'h800, 3'd5, 1'b1, 2'b11, 0, 3 + T + 1, s0, o2, o3, bf, bd);
    total++; if (bif.BERR !== 1'b1) begin bad++; $display("FAIL pre_reset_berr: got %b want 1", bif.BERR); end
    #2 rst = 1'b1;
    #1;
    ovl_m = 1'b1;
    total++; if (bif.BERR !== 1'b0) begin bad++; $display("FAIL async_reset_berr: got %b want 0", bif.BERR); end
    total++; if (bif.OVERLAY !== 1'b1) begin bad++; $display("FAIL async_reset_overlay: got %b want 1", bif.OVERLAY); end
    bif.nAS = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_cycle(12'h800, 3'd5, 1'b1, 2'b11, 0, 3 + T + 2, s0, o2, o3, bf, bd);
    total++; if (bf != exp_berr_edge(0)) begin bad++; $display("FAIL post_reset_timeout: got edge %0d want %0d", bf, exp_berr_edge(0)); end
    end_cycle(b2, b3);
  endtask

  task automatic test_random();
    logic [2:0] s0, exp_s;
    logic o2, o3, b2, b3;
    logic [11:0] a;
    logic [2:0] fc;
    logic rnw;
    logic [1:0] dp;
    int bf, k, ne, exp_b;
    bit bd, exp_o3;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ovl_m = 1'b1;
      end
      case ($urandom_range(0, 4))
        0: a = 12'($urandom_range(0, 'hFF));
        1: a = 12'($urandom_range('hFF0, 'hFFE));
        2: a = 12'hFFF;
        3: a = 12'($urandom_range('h100, 'hFEF));
        default: a = 12'($urandom);
      endcase
      fc  = 3'($urandom_range(0, 7));
      rnw = 1'($urandom);
      case ($urandom_range(0, 2))
        0: dp = 2'b00;
        1: dp = 2'b01;
        default: dp = 2'b10;
      endcase
      case ($urandom_range(0, 4))
        0: k = 0;
        1: k = T + 1;
        2: k = T + 2;
        default: k = $urandom_range(1, T + 4);
      endcase
      exp_b = exp_berr_edge(k);
      ne = (exp_b == 0) ? ((k > 2 ? k : 2) + 5) : (3 + T + 2);
      exp_s  = exp_sel(a, fc, rnw, 1'b0, ovl_m);
      exp_o3 = ovl_m && !is_rom(a, fc);
      run_cycle(a, fc, rnw, dp, k, ne, s0, o2, o3, bf, bd);
      total++; if (s0 !== exp_s) begin bad++; $display("FAIL rnd%0d_sel a=%h fc=%0d rnw=%b: got %b want %b", it, a, fc, rnw, s0, exp_s); end
      total++; if (o2 !== ovl_m || o3 !== exp_o3) begin bad++; $display("FAIL rnd%0d_overlay: got %b%b want %b%b", it, o2, o3, ovl_m, exp_o3); end
      ovl_m = exp_o3;
      total++; if (bf != exp_b || bd) begin bad++; $display("FAIL rnd%0d_berr k=%0d: got edge %0d drop %0d want edge %0d drop 0", it, k, bf, bd, exp_b); end
      end_cycle(b2, b3);
      total++; if (b3 !== 1'b0) begin bad++; $display("FAIL rnd%0d_berr_release: got %b want 0", it, b3); end
    end
  endtask

  initial begin
    test_reset();
    test_overlay_rdwr();
    test_overlay_clear();
    test_timeout();
    test_race();
    test_cpu_space();
    test_reset_mid_fault();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
